rule_unit_arb: RTL and testbench
================================

Name: rule_unit_arb

Overview:
- Shares one rule_unit between NUM_REQ rule requesters (per-lane rule FIFOs after the rule-match stage).
- Round-robin arbitration with packet-granular locking: all rules of one packet are issued contiguously.
- rule_unit has no backpressure. This block issues under credit against an internal output FIFO, tags every issued beat through a PIPE_LAT delay line, and returns per-beat results with the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, >=2)
- RULE_AWIDTH, 16, rule ID width
- PIPE_LAT, 16, cycles from ru_rule_valid to ru_match/ru_rule_out valid; must equal the instanced rule_unit latency
- OUT_DEPTH, 32, output FIFO depth (power of 2, > PIPE_LAT)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester accept
- req_rule  in  NUM_REQ*RULE_AWIDTH  rule ID (0 = null rule)
- req_src_port  in  NUM_REQ*16  packet source port
- req_dst_port  in  NUM_REQ*16  packet destination port
- req_tcp  in  NUM_REQ  packet is TCP
- req_last  in  NUM_REQ  last rule of packet
- ru_rule_data  out  RULE_AWIDTH  to rule_unit in_rule_data
- ru_rule_valid  out  1  to rule_unit in_rule_valid
- ru_src_port  out  16  to rule_unit src_port
- ru_dst_port  out  16  to rule_unit dst_port
- ru_tcp  out  1  to rule_unit tcp
- ru_match  in  1  from rule_unit rule_pg_match
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- out_req_id  out  $clog2(NUM_REQ)  originating requester
- out_rule  out  RULE_AWIDTH  issued rule ID (returned even when match=0)
- out_match  out  1  port-group match
- out_last  out  1  last result of packet

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, rr_ptr=0, owner=0.
  - Delay-line valids cleared; FIFO emptied; inflight=0.
  - All ru_* outputs 0; req_ready=0 during reset; out_valid=0.
  - Results from beats issued before reset are discarded; their delay-line valid is already cleared.
- credit_ok = (inflight + fifo_count) < OUT_DEPTH. inflight counts beats issued but not yet written to the FIFO. Widths: $clog2(OUT_DEPTH)+1.
- FSM IDLE:
  - winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner] = credit_ok; all other ready bits are 0.
  - Accepted non-last beat: -> LOCKED, owner=winner.
  - Accepted last beat: stay IDLE, rr_ptr=winner+1 (wraps modulo NUM_REQ).
- FSM LOCKED:
  - req_ready[owner] = credit_ok; all other ready bits are 0.
  - Owner's req_valid may drop between beats; lock is held.
  - Accepted last beat: -> IDLE, rr_ptr=owner+1.
- req_ready is combinational from registered state, credit count and req_valid. A requester's ready never depends on its own valid outside IDLE.
- Issue (accept at cycle T):
  - At T+1: ru_rule_valid=1, with ru_rule_data, ru_src_port, ru_dst_port, ru_tcp registered from the accepted requester. ru_rule_valid=0 otherwise.
  - ru_rule_data and the ports hold their last value when not valid.
  - At T+1: tag {valid, req_id, rule, last} enters a PIPE_LAT-deep shift register; inflight increments.
  - At T+1+PIPE_LAT: tag exits together with ru_match and is written to the FIFO as {req_id, rule, match, last}; inflight decrements.
  - Simultaneous increment and decrement leaves inflight unchanged.
- Null rule (rule=0) is issued normally; out_match=0 is returned for it.
- Output FIFO:
  - Show-ahead; out_valid = !empty.
  - Pop on out_valid&out_ready.
  - Write and pop in the same cycle are allowed, including on a full FIFO.
  - Empty-to-valid latency is 1 cycle after write, so the first result appears at T+2+PIPE_LAT.
- Overflow cannot occur by construction. A simulation assertion fires on write-when-full.
- Results return in issue order. A packet's results are contiguous.
- Throughput: 1 beat/cycle while credit is available.

Decomposition:
- Shared package (struct_s): ru_tag_t {req_id, rule, last} and ru_result_t {req_id, rule, match, last}; RULE_AWIDTH is reused from there.
- One sub-module: ru_result_fifo, a parameterised show-ahead FIFO with count output.
- Round-robin pick, FSM, credit counter and delay line stay in rule_unit_arb.

Test Plan:
- Single requester 0: 3 beats, rules 5, 9, 12, last on 12; rule_unit model matches rule 9 only. Expect results at T+18.. in order: (0,5,0,0), (0,9,1,0), (0,12,0,1).
- All 4 requesters valid with 2-beat packets, rr_ptr=0. Expect grant order 0,0,1,1,2,2,3,3; no interleaving; rr_ptr=0 after the 8th beat.
- Requester 1 mid-packet drops valid for 5 cycles while requester 2 is valid. Expect requester 2 is never ready until requester 1 issues its last beat.
- out_ready=0 with continuous traffic. Expect exactly 32 beats accepted, then all ready bits 0. Then out_ready=1 for 1 cycle: 1 pop leads to exactly 1 further accept; no FIFO overflow assertion.
- Null rule 0 from requester 3 with last=1. Expect result (3,0,0,1), ru_rule_valid pulsed once.
- rst_n low for 1 cycle with 10 beats in flight. Expect no out_valid within 2*PIPE_LAT cycles after reset, state IDLE, rr_ptr=0; a fresh beat then returns correctly.

Source files
------------

// File: rtl/rule_unit_arb_pkg.sv
// Shared sizing, FSM encodings and tag/result records for the rule_unit arbiter.
package rule_unit_arb_pkg;

    localparam int NUM_REQ     = 4;
    localparam int RULE_AWIDTH = 16;
    localparam int REQ_IDW     = $clog2(NUM_REQ);

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    typedef struct packed {
        logic [REQ_IDW-1:0]     req_id;
        logic [RULE_AWIDTH-1:0] rule;
        logic                   last;
    } ru_tag_t;

    typedef struct packed {
        logic [REQ_IDW-1:0]     req_id;
        logic [RULE_AWIDTH-1:0] rule;
        logic                   match;
        logic                   last;
    } ru_result_t;

    // First valid requester at or after ptr, wrapping; returns ptr when none is valid.
    function automatic logic [REQ_IDW-1:0] rrPick(input logic [NUM_REQ-1:0] valid,
                                                  input logic [REQ_IDW-1:0] ptr);
        logic [REQ_IDW-1:0] pick;
        logic [REQ_IDW-1:0] idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + REQ_IDW'(k);
            if (valid[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rule_unit_arb_fifo.sv
// Show-ahead result FIFO with occupancy count; a write may coincide with a pop,
// including when full.
module ru_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      count_q, count_d;
    logic             full, doWr, doRd;

    assign full      = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign doRd      = rd_en_i && !empty_o;
    assign doWr      = wr_en_i && (!full || doRd);
    assign rd_data_o = mem_q[rdPtr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        case ({doWr, doRd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWr) wrPtr_q <= wrPtr_q + 1'b1;
            if (doRd) rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) mem_q[wrPtr_q] <= wr_data_i;
    end

    // Issue credit should make this impossible; a hit means the accounting broke.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_i && full && !rd_en_i));

endmodule

// File: rtl/rule_unit_arb.sv
// Round-robin arbiter sharing one rule_unit between requesters, with per-packet
// locking, credit-based issue and a tagged delay line that pairs rule_unit matches.
module rule_unit_arb
    import rule_unit_arb_pkg::*;
#(
    parameter int PIPE_LAT  = 16,
    parameter int OUT_DEPTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*RULE_AWIDTH-1:0] req_rule,
    input  logic [NUM_REQ*16-1:0]          req_src_port,
    input  logic [NUM_REQ*16-1:0]          req_dst_port,
    input  logic [NUM_REQ-1:0]             req_tcp,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [RULE_AWIDTH-1:0]         ru_rule_data,
    output logic                           ru_rule_valid,
    output logic [15:0]                    ru_src_port,
    output logic [15:0]                    ru_dst_port,
    output logic                           ru_tcp,
    input  logic                           ru_match,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [REQ_IDW-1:0]             out_req_id,
    output logic [RULE_AWIDTH-1:0]         out_rule,
    output logic                           out_match,
    output logic                           out_last
);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic                   state_q, state_d;
    logic [REQ_IDW-1:0]     rrPtr_q, rrPtr_d;
    logic [REQ_IDW-1:0]     owner_q, owner_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0]       fifoCount;
    logic                   fifoEmpty;
    logic                   creditOk;
    logic [REQ_IDW-1:0]     winner, grantId;
    logic                   accept, acceptLast;

    logic                   ruValid_q;
    logic [RULE_AWIDTH-1:0] ruRule_q;
    logic [15:0]            ruSrc_q, ruDst_q;
    logic                   ruTcp_q;
    logic [REQ_IDW-1:0]     issueId_q;
    logic                   issueLast_q;

    logic                   tagValid_q [PIPE_LAT];
    ru_tag_t                tag_q      [PIPE_LAT];
    logic                   fifoWr;
    ru_result_t             fifoWdata, fifoRdata;

    // Beats in the rule_unit pipe already own a FIFO slot, so they count against credit.
    assign creditOk = (inflight_q + fifoCount) < CNT_W'(OUT_DEPTH);

    assign winner     = rrPick(req_valid, rrPtr_q);
    assign grantId    = (state_q == STATE_LOCKED) ? owner_q : winner;
    assign accept     = |(req_valid & req_ready);
    assign acceptLast = req_last[grantId];

    always_comb begin
        req_ready = '0;
        if (rst_n && creditOk && ((state_q == STATE_LOCKED) || (|req_valid)))
            req_ready[grantId] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        owner_d = owner_q;
        if (accept) begin
            if (acceptLast) begin
                state_d = STATE_IDLE;
                rrPtr_d = grantId + 1'b1;
            end else begin
                state_d = STATE_LOCKED;
                owner_d = grantId;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !fifoWr)      inflight_d = inflight_q + 1'b1;
        else if (!accept && fifoWr) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            rrPtr_q     <= '0;
            owner_q     <= '0;
            inflight_q  <= '0;
            ruValid_q   <= 1'b0;
            ruRule_q    <= '0;
            ruSrc_q     <= '0;
            ruDst_q     <= '0;
            ruTcp_q     <= 1'b0;
            issueId_q   <= '0;
            issueLast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            owner_q    <= owner_d;
            inflight_q <= inflight_d;
            ruValid_q  <= accept;
            if (accept) begin
                ruRule_q    <= req_rule[int'(grantId) * RULE_AWIDTH +: RULE_AWIDTH];
                ruSrc_q     <= req_src_port[int'(grantId) * 16 +: 16];
                ruDst_q     <= req_dst_port[int'(grantId) * 16 +: 16];
                ruTcp_q     <= req_tcp[grantId];
                issueId_q   <= grantId;
                issueLast_q <= acceptLast;
            end
        end
    end

    // Tag delay line lines up with the rule_unit latency; only valids need clearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) tagValid_q[i] <= 1'b0;
        end else begin
            tagValid_q[0] <= ruValid_q;
            for (int i = 1; i < PIPE_LAT; i++) tagValid_q[i] <= tagValid_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= '{req_id: issueId_q, rule: ruRule_q, last: issueLast_q};
        for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end

    assign fifoWr    = tagValid_q[PIPE_LAT-1];
    assign fifoWdata = '{req_id: tag_q[PIPE_LAT-1].req_id,
                         rule:   tag_q[PIPE_LAT-1].rule,
                         match:  ru_match,
                         last:   tag_q[PIPE_LAT-1].last};

    ru_result_fifo #(
        .WIDTH($bits(ru_result_t)),
        .DEPTH(OUT_DEPTH)
    ) uResultFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (fifoWr),
        .wr_data_i (fifoWdata),
        .rd_en_i   (out_ready),
        .rd_data_o (fifoRdata),
        .empty_o   (fifoEmpty),
        .count_o   (fifoCount)
    );

    assign ru_rule_valid = ruValid_q;
    assign ru_rule_data  = ruRule_q;
    assign ru_src_port   = ruSrc_q;
    assign ru_dst_port   = ruDst_q;
    assign ru_tcp        = ruTcp_q;

    assign out_valid  = !fifoEmpty;
    assign out_req_id = fifoRdata.req_id;
    assign out_rule   = fifoRdata.rule;
    assign out_match  = fifoRdata.match;
    assign out_last   = fifoRdata.last;

endmodule

// File: tb/tb_rule_unit_arb.sv
// Scoreboard bench for rule_unit_arb with a behavioural rule_unit model that
// answers PIPE_LAT cycles after each issued beat.
module tb_rule_unit_arb;
    import rule_unit_arb_pkg::*;

    localparam int PIPE_LAT  = 16;
    localparam int OUT_DEPTH = 32;

    typedef struct packed {
        logic [RULE_AWIDTH-1:0] rule;
        logic [15:0]            src;
        logic [15:0]            dst;
        logic                   tcp;
        logic                   last;
    } beat_t;

    typedef struct {
        logic [REQ_IDW-1:0] id;
        beat_t              b;
        int                 cyc;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*RULE_AWIDTH-1:0] req_rule;
    logic [NUM_REQ*16-1:0]          req_src_port;
    logic [NUM_REQ*16-1:0]          req_dst_port;
    logic [NUM_REQ-1:0]             req_tcp;
    logic [NUM_REQ-1:0]             req_last;
    logic [RULE_AWIDTH-1:0]         ru_rule_data;
    logic                           ru_rule_valid;
    logic [15:0]                    ru_src_port;
    logic [15:0]                    ru_dst_port;
    logic                           ru_tcp;
    logic                           ru_match;
    logic                           out_valid;
    logic                           out_ready;
    logic [REQ_IDW-1:0]             out_req_id;
    logic [RULE_AWIDTH-1:0]         out_rule;
    logic                           out_match;
    logic                           out_last;

    beat_t reqQ [NUM_REQ][$];
    exp_t  issueQ[$];
    exp_t  resQ[$];
    int    grantLog[$];
    bit    hold [NUM_REQ];
    bit    outReadyCfg;
    bit    checkLat;
    int    cycle;
    int    checks;
    int    passes;
    int    acceptCount;
    int    issueCount;

    logic [PIPE_LAT-1:0] mdlMatch = '0;

    always #5 clk = ~clk;

    rule_unit_arb #(
        .PIPE_LAT  (PIPE_LAT),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rule     (req_rule),
        .req_src_port (req_src_port),
        .req_dst_port (req_dst_port),
        .req_tcp      (req_tcp),
        .req_last     (req_last),
        .ru_rule_data (ru_rule_data),
        .ru_rule_valid(ru_rule_valid),
        .ru_src_port  (ru_src_port),
        .ru_dst_port  (ru_dst_port),
        .ru_tcp       (ru_tcp),
        .ru_match     (ru_match),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_req_id   (out_req_id),
        .out_rule     (out_rule),
        .out_match    (out_match),
        .out_last     (out_last)
    );

    // Behavioural rule_unit: a TCP rule matches when rule mod 7 equals 2; null never matches.
    function automatic logic matchFn(input logic [RULE_AWIDTH-1:0] rule, input logic tcp);
        return tcp && (rule != '0) && ((rule % 7) == 2);
    endfunction

    always @(posedge clk)
        mdlMatch <= {mdlMatch[PIPE_LAT-2:0], ru_rule_valid && matchFn(ru_rule_data, ru_tcp)};
    assign ru_match = mdlMatch[PIPE_LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic pushBeat(input int r, input int rule, input int src, input int dst,
                            input bit tcp, input bit last);
        beat_t b;
        b.rule = RULE_AWIDTH'(rule);
        b.src  = 16'(src);
        b.dst  = 16'(dst);
        b.tcp  = tcp;
        b.last = last;
        reqQ[r].push_back(b);
    endtask

    // One clock: drive requesters at negedge, then score issue, accept and result.
    task automatic applyStimulus();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hold[i] && reqQ[i].size() > 0) begin
                req_valid[i]                             = 1'b1;
                req_rule[i*RULE_AWIDTH +: RULE_AWIDTH]   = reqQ[i][0].rule;
                req_src_port[i*16 +: 16]                 = reqQ[i][0].src;
                req_dst_port[i*16 +: 16]                 = reqQ[i][0].dst;
                req_tcp[i]                               = reqQ[i][0].tcp;
                req_last[i]                              = reqQ[i][0].last;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        out_ready = outReadyCfg;
        #1;
        if (ru_rule_valid) begin
            issueCount++;
            if (issueQ.size() == 0) begin
                checkOutput("unexpected issue", 1, 0);
            end else begin
                e = issueQ.pop_front();
                checkOutput("ru_rule_data", ru_rule_data, e.b.rule);
                checkOutput("ru ports/tcp", {ru_src_port, ru_dst_port, ru_tcp}, {e.b.src, e.b.dst, e.b.tcp});
            end
        end
        if (|req_valid) checkOutput("ready onehot", ($countones(req_ready) <= 1), 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id  = REQ_IDW'(i);
                e.b   = reqQ[i].pop_front();
                e.cyc = cycle;
                issueQ.push_back(e);
                resQ.push_back(e);
                grantLog.push_back(i);
                acceptCount++;
            end
        end
        if (out_valid && out_ready) begin
            if (resQ.size() == 0) begin
                checkOutput("unexpected result", 1, 0);
            end else begin
                e = resQ.pop_front();
                checkOutput("result", {out_req_id, out_rule, out_match, out_last},
                            {e.id, e.b.rule, matchFn(e.b.rule, e.b.tcp), e.b.last});
                if (checkLat) checkOutput("result latency", cycle - e.cyc, PIPE_LAT + 2);
            end
        end
        cycle++;
    endtask

    function automatic bit pending();
        bit p;
        p = (issueQ.size() != 0) || (resQ.size() != 0);
        for (int i = 0; i < NUM_REQ; i++) if (reqQ[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic runUntilDrained(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (pending() && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, pending(), 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
        issueQ.delete();
        resQ.delete();
        #1;
        checkOutput("ready in reset", req_ready, 0);
        @(negedge clk);
        checkOutput("ru_rule_valid after reset", ru_rule_valid, 0);
        checkOutput("ru outputs after reset", {ru_rule_data, ru_src_port, ru_dst_port, ru_tcp}, 0);
        checkOutput("out_valid after reset", out_valid, 0);
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    task automatic testSingle();
        checkLat = 1'b1;
        pushBeat(0, 5, 100, 200, 1'b1, 1'b0);
        pushBeat(0, 9, 100, 200, 1'b1, 1'b0);
        pushBeat(0, 12, 100, 200, 1'b1, 1'b1);
        runUntilDrained("single drain", 100);
        checkLat = 1'b0;
    endtask

    task automatic testRoundRobin();
        int expGrant [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1};
        grantLog.delete();
        for (int r = 0; r < NUM_REQ; r++) begin
            pushBeat(r, 16 + r, 300 + r, 400 + r, 1'b1, 1'b0);
            pushBeat(r, 30 + r, 300 + r, 400 + r, 1'b1, 1'b1);
        end
        runUntilDrained("rr drain", 200);
        pushBeat(1, 44, 1, 2, 1'b1, 1'b1);
        pushBeat(0, 51, 3, 4, 1'b1, 1'b1);
        runUntilDrained("rr wrap drain", 100);
        checkOutput("rr grant count", grantLog.size(), 10);
        for (int k = 0; k < 10 && k < grantLog.size(); k++)
            checkOutput($sformatf("rr grant[%0d]", k), grantLog[k], expGrant[k]);
    endtask

    task automatic testLockHold();
        int expGrant [4] = '{1, 1, 1, 2};
        int n;
        grantLog.delete();
        pushBeat(1, 61, 10, 11, 1'b1, 1'b0);
        pushBeat(1, 62, 10, 11, 1'b0, 1'b0);
        pushBeat(1, 63, 10, 11, 1'b1, 1'b1);
        n = 0;
        while (grantLog.size() == 0 && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("lock first grant", grantLog.size(), 1);
        hold[1] = 1'b1;
        pushBeat(2, 70, 20, 21, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput("lock blocks req2", req_ready[2], 0);
            checkOutput("lock owner ready", req_ready[1], 1);
        end
        hold[1] = 1'b0;
        runUntilDrained("lock drain", 100);
        checkOutput("lock grant count", grantLog.size(), 4);
        for (int k = 0; k < 4 && k < grantLog.size(); k++)
            checkOutput($sformatf("lock grant[%0d]", k), grantLog[k], expGrant[k]);
    endtask

    task automatic testNullRule();
        issueCount = 0;
        pushBeat(3, 0, 55, 66, 1'b1, 1'b1);
        runUntilDrained("null drain", 100);
        checkOutput("null issue pulses", issueCount, 1);
    endtask

    task automatic testBackpressure();
        int base;
        base = acceptCount;
        outReadyCfg = 1'b0;
        for (int k = 0; k < 40; k++) pushBeat(0, 100 + k, 500 + k, 600 + k, k[0], (k % 4) == 3);
        repeat (60) applyStimulus();
        checkOutput("full accepts", acceptCount - base, OUT_DEPTH);
        checkOutput("full ready", req_ready, 0);
        checkOutput("full out_valid", out_valid, 1);
        outReadyCfg = 1'b1;
        applyStimulus();
        outReadyCfg = 1'b0;
        repeat (6) applyStimulus();
        checkOutput("one pop one accept", acceptCount - base, OUT_DEPTH + 1);
        outReadyCfg = 1'b1;
        runUntilDrained("backpressure drain", 300);
    endtask

    task automatic testResetInFlight();
        int  expGrant [2] = '{0, 1};
        int  base;
        bit  sawValid;
        base = acceptCount;
        for (int k = 0; k < 10; k++) pushBeat(0, 200 + k, 7, 8, 1'b1, (k % 5) == 4);
        repeat (12) applyStimulus();
        checkOutput("beats in flight", acceptCount - base, 10);
        resetDut();
        sawValid = 1'b0;
        for (int c = 0; c < 2 * PIPE_LAT; c++) begin
            applyStimulus();
            sawValid |= out_valid;
        end
        checkOutput("no stale results", sawValid, 0);
        grantLog.delete();
        pushBeat(1, 9, 30, 31, 1'b1, 1'b1);
        pushBeat(0, 16, 32, 33, 1'b1, 1'b1);
        runUntilDrained("post reset drain", 100);
        checkOutput("post reset grant count", grantLog.size(), 2);
        for (int k = 0; k < 2 && k < grantLog.size(); k++)
            checkOutput($sformatf("post reset grant[%0d]", k), grantLog[k], expGrant[k]);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_rule     = '0;
        req_src_port = '0;
        req_dst_port = '0;
        req_tcp      = '0;
        req_last     = '0;
        out_ready    = 1'b0;
        outReadyCfg  = 1'b1;
        checkLat     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) hold[i] = 1'b0;
        cycle = 0; checks = 0; passes = 0; acceptCount = 0; issueCount = 0;

        resetDut();
        $display("[TB] single requester");
        testSingle();
        resetDut();
        $display("[TB] round robin");
        testRoundRobin();
        $display("[TB] lock hold");
        testLockHold();
        $display("[TB] null rule");
        testNullRule();
        $display("[TB] output backpressure");
        testBackpressure();
        $display("[TB] reset with beats in flight");
        testResetInFlight();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
